// File: rtl/mult32x32_arb_pkg.sv
// Shared types and default sizing for the mult32x32 round-robin arbiter.
package mult32x32_arb_pkg;

  localparam int unsigned NumReqDef = 4;
  localparam int unsigned AWDef     = 32;
  localparam int unsigned BWDef     = 32;
  localparam int unsigned IdxWDef   = $clog2(NumReqDef);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitHi,
    StWaitLo,
    StResp
  } arb_state_t;

endpackage

// File: rtl/mult32x32_arbiter_if.sv
// Requester and multiplier-side bus of the arbiter; slave = arbiter view.
interface mult32x32_arbiter_if
  import mult32x32_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDef,
  parameter int unsigned A_W     = AWDef,
  parameter int unsigned B_W     = BWDef
) ();
  localparam int unsigned P_W = A_W + B_W;

  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     done;
  logic [P_W-1:0]         rsp_product;
  logic                   arb_busy;
  logic                   mult_start;
  logic [A_W-1:0]         mult_a;
  logic [B_W-1:0]         mult_b;
  logic                   mult_busy;
  logic [P_W-1:0]         mult_product;

  modport slave (
    input  req, req_a, req_b, mult_busy, mult_product,
    output done, rsp_product, arb_busy, mult_start, mult_a, mult_b
  );

  modport master (
    output req, req_a, req_b, mult_busy, mult_product,
    input  done, rsp_product, arb_busy, mult_start, mult_a, mult_b
  );

endinterface

// File: rtl/mult32x32_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after rr_ptr_i, wrapping.
module mult32x32_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  // Scan from farthest to nearest so the nearest set bit after the pointer wins.
  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      automatic int unsigned k = (32'(rr_ptr_i) + i) % NUM_REQ;
      if (req_i[IDX_W'(k)]) begin
        gnt_idx_o   = IDX_W'(k);
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult32x32_arbiter.sv
// Round-robin sharing of one mult32x32 among NUM_REQ requesters.
// Optional per-requester done counters on op_count_o when MULT_ARB_STATS_EN is defined.
module mult32x32_arbiter
  import mult32x32_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDef,
  parameter int unsigned A_W     = AWDef,
  parameter int unsigned B_W     = BWDef
) (
  input logic                    clk,
  input logic                    reset,
  mult32x32_arbiter_if.slave     bus
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]  op_count_o
`endif
);

  localparam int unsigned P_W  = A_W + B_W;
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_t      state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic            pick_valid;
  logic [A_W-1:0]  a_q, a_d;
  logic [B_W-1:0]  b_q, b_d;
  logic [P_W-1:0]  prod_q, prod_d;
  logic            abort_q, abort_d;
  logic            lost;

  mult32x32_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_pick (
    .req_i       (bus.req),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_idx_o   (pick_idx),
    .gnt_valid_o (pick_valid)
  );

  // Requester withdrew before its result: finish the op but stay silent.
  assign lost = abort_q | ~bus.req[gnt_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q    <= '0;
      rr_ptr_q <= IdxW'(NUM_REQ - 1);
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    abort_d  = abort_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d    = pick_idx;
          rr_ptr_d = pick_idx;
          a_d      = bus.req_a[pick_idx*A_W +: A_W];
          b_d      = bus.req_b[pick_idx*B_W +: B_W];
          abort_d  = 1'b0;
          state_d  = StStart;
        end
      end
      StStart: begin
        abort_d = lost;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        abort_d = lost;
        if (bus.mult_busy) state_d = StWaitLo;
      end
      StWaitLo: begin
        abort_d = lost;
        if (!bus.mult_busy) begin
          prod_d  = lost ? '0 : bus.mult_product;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.done       = '0;
    bus.arb_busy   = (state_q != StIdle);
    bus.mult_start = (state_q == StStart);
    if (state_q == StResp && !abort_q) bus.done[gnt_q] = 1'b1;
  end

  assign bus.mult_a      = a_q;
  assign bus.mult_b      = b_q;
  assign bus.rsp_product = prod_q;

`ifdef MULT_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)           cnt_q <= '0;
      else if (bus.done[i]) cnt_q <= cnt_q + 16'd1;
    end
    assign op_count_o[16*i +: 16] = cnt_q;
  end
`endif

endmodule
